// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants, MEM/WB buffer state encoding and the default-width entry type.
// No logic; imported by the MEM/WB staging files.
package cpu_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CTRL_W_DEF = 2;
    localparam int EXP_W_DEF  = 3;

    localparam logic [1:0] CTRL_OP_NOP        = 2'd0;
    localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
    localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0]   pc;
        logic                  en;
        logic                  br_flag;
        logic [CTRL_W_DEF-1:0] ctrl_op;
        logic [REG_AW_DEF-1:0] dst_addr;
        logic                  gpr_we_;
        logic [EXP_W_DEF-1:0]  exp_code;
        logic [XLEN_DEF-1:0]   out;
    } mem_entry_t;

endpackage

// File: rtl/mem_stage_buf_if.sv
// MEM/WB stage handshake bundle: upstream in_* side and downstream out_* side.
// master = memory-access unit / write-back pair, slave = the stage buffer.
interface mem_stage_buf_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 2,
    parameter int EXP_W  = 3
) ();
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic              in_en;
    logic              in_br_flag;
    logic [CTRL_W-1:0] in_ctrl_op;
    logic [REG_AW-1:0] in_dst_addr;
    logic              in_gpr_we_;
    logic [EXP_W-1:0]  in_exp_code;
    logic [XLEN-1:0]   in_out;
    logic              in_miss_align;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic              out_en;
    logic              out_br_flag;
    logic [CTRL_W-1:0] out_ctrl_op;
    logic [REG_AW-1:0] out_dst_addr;
    logic              out_gpr_we_;
    logic [EXP_W-1:0]  out_exp_code;
    logic [XLEN-1:0]   out_out;

    modport master (
        output in_valid, in_pc, in_en, in_br_flag, in_ctrl_op, in_dst_addr,
               in_gpr_we_, in_exp_code, in_out, in_miss_align, out_ready,
        input  in_ready, out_valid, out_pc, out_en, out_br_flag, out_ctrl_op,
               out_dst_addr, out_gpr_we_, out_exp_code, out_out
    );

    modport slave (
        input  in_valid, in_pc, in_en, in_br_flag, in_ctrl_op, in_dst_addr,
               in_gpr_we_, in_exp_code, in_out, in_miss_align, out_ready,
        output in_ready, out_valid, out_pc, out_en, out_br_flag, out_ctrl_op,
               out_dst_addr, out_gpr_we_, out_exp_code, out_out
    );
endinterface

// File: rtl/mem_entry_fmt.sv
// Formats one incoming MEM entry, replacing it with a misaligned-access exception entry when flagged.
// Latency: combinational. Backpressure: none (pure function of its inputs).
module mem_entry_fmt
    import cpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 2,
    parameter int EXP_W  = 3,
    parameter int ENT_W  = 2 * XLEN + CTRL_W + REG_AW + EXP_W + 3
) (
    input  logic [XLEN-1:0]   pc,
    input  logic              en,
    input  logic              br_flag,
    input  logic [CTRL_W-1:0] ctrl_op,
    input  logic [REG_AW-1:0] dst_addr,
    input  logic              gpr_we_,
    input  logic [EXP_W-1:0]  exp_code,
    input  logic [XLEN-1:0]   res,
    input  logic              miss_align,
    output logic [ENT_W-1:0]  ent
);
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic              en;
        logic              br_flag;
        logic [CTRL_W-1:0] ctrl_op;
        logic [REG_AW-1:0] dst_addr;
        logic              gpr_we_;
        logic [EXP_W-1:0]  exp_code;
        logic [XLEN-1:0]   out;
    } ent_t;

    ent_t f;

    always_comb begin
        f.pc       = pc;
        f.en       = en;
        f.br_flag  = br_flag;
        f.ctrl_op  = ctrl_op;
        f.dst_addr = dst_addr;
        f.gpr_we_  = gpr_we_;
        f.exp_code = exp_code;
        f.out      = res;
        // A misaligned access must not write a register; it becomes a pure exception marker.
        if (miss_align) begin
            f.ctrl_op  = CTRL_W'(CTRL_OP_NOP);
            f.dst_addr = '0;
            f.gpr_we_  = 1'b1;
            f.exp_code = EXP_W'(ISA_EXP_MISS_ALIGN);
            f.out      = '0;
        end
    end

    assign ent = f;
endmodule

// File: rtl/mem_stage_buf.sv
// MEM/WB elastic stage buffer; MEM_STAGE_SKID_EN adds a second (skid) entry and registered in_ready.
// Latency: 1 cycle accept-to-out_valid, 1 entry/cycle throughput.
// Backpressure: skid build in_ready = state != TWO (registered); otherwise in_ready = !out_valid || out_ready.
module mem_stage_buf
    import cpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 2,
    parameter int EXP_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    mem_stage_buf_if.slave   bus
);
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic              en;
        logic              br_flag;
        logic [CTRL_W-1:0] ctrl_op;
        logic [REG_AW-1:0] dst_addr;
        logic              gpr_we_;
        logic [EXP_W-1:0]  exp_code;
        logic [XLEN-1:0]   out;
    } ent_t;

    localparam int ENT_W = $bits(ent_t);

    localparam ent_t ENT_RST = '{
        pc:       '0,
        en:       1'b0,
        br_flag:  1'b0,
        ctrl_op:  CTRL_W'(CTRL_OP_NOP),
        dst_addr: '0,
        gpr_we_:  1'b1,
        exp_code: EXP_W'(ISA_EXP_NO_EXP),
        out:      '0
    };

    ent_t       in_ent;
    ent_t       main_q;
    ent_t       main_nxt;
    buf_state_e state_q;
    buf_state_e state_d;
    logic       accept;
    logic       emit;
    logic       main_ld;

    mem_entry_fmt #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .CTRL_W (CTRL_W),
        .EXP_W  (EXP_W),
        .ENT_W  (ENT_W)
    ) u_fmt (
        .pc         (bus.in_pc),
        .en         (bus.in_en),
        .br_flag    (bus.in_br_flag),
        .ctrl_op    (bus.in_ctrl_op),
        .dst_addr   (bus.in_dst_addr),
        .gpr_we_    (bus.in_gpr_we_),
        .exp_code   (bus.in_exp_code),
        .res        (bus.in_out),
        .miss_align (bus.in_miss_align),
        .ent        (in_ent)
    );

    assign bus.out_valid = (state_q != EMPTY);
`ifdef MEM_STAGE_SKID_EN
    ent_t skid_q;
    logic skid_ld;
    logic main_from_skid;

    assign bus.in_ready = (state_q != TWO);
    assign main_nxt     = main_from_skid ? skid_q : in_ent;
`else
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign main_nxt     = in_ent;
`endif

    assign accept = bus.in_valid && bus.in_ready;
    assign emit   = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
`ifdef MEM_STAGE_SKID_EN
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
`endif
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_ld = 1'b1;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    main_ld = 1'b1;
                end else if (emit) begin
                    state_d = EMPTY;
`ifdef MEM_STAGE_SKID_EN
                end else if (accept) begin
                    state_d = TWO;
                    skid_ld = 1'b1;
`endif
                end
            end
`ifdef MEM_STAGE_SKID_EN
            TWO: begin
                // in_ready is low here, so the only move is draining skid into main.
                if (emit) begin
                    state_d        = ONE;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_q <= ENT_RST;
        end else if (main_ld) begin
            main_q <= main_nxt;
        end
    end

`ifdef MEM_STAGE_SKID_EN
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            skid_q <= ENT_RST;
        end else if (skid_ld) begin
            skid_q <= in_ent;
        end
    end
`endif

    assign bus.out_pc       = main_q.pc;
    assign bus.out_en       = main_q.en;
    assign bus.out_br_flag  = main_q.br_flag;
    assign bus.out_ctrl_op  = main_q.ctrl_op;
    assign bus.out_dst_addr = main_q.dst_addr;
    assign bus.out_gpr_we_  = main_q.gpr_we_;
    assign bus.out_exp_code = main_q.exp_code;
    assign bus.out_out      = main_q.out;
endmodule

// File: doc/mem_stage_buf.md
# mem_stage_buf

Parametrised MEM/WB pipeline stage buffer that sits between the memory-access unit and write-back. It replaces fixed stall-based staging with a valid/ready elastic handshake and an optional two-entry skid buffer. It captures the EX/MEM bundle plus the memory result, and substitutes a misaligned-access exception entry when required. It supports flush, synchronous reset and full 1-entry-per-cycle throughput.

## Interface
- XLEN, 32, width of pc and result
- REG_AW, 5, GPR address width
- CTRL_W, 2, control-register op width
- EXP_W, 3, exception code width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held and incoming entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage accepts this cycle
- in_pc  in  XLEN  program counter
- in_en  in  1  entry-valid bit carried through
- in_br_flag  in  1  branch flag
- in_ctrl_op  in  CTRL_W  control-register op
- in_dst_addr  in  REG_AW  GPR write address
- in_gpr_we_  in  1  GPR write enable, active-low
- in_exp_code  in  EXP_W  upstream exception code
- in_out  in  XLEN  memory/ALU result
- in_miss_align  in  1  misaligned access for this entry
- out_valid  out  1  entry presented to WB
- out_ready  in  1  WB consumes
- out_pc, out_en, out_br_flag, out_ctrl_op, out_dst_addr, out_gpr_we_, out_exp_code, out_out  out  widths as inputs  held entry

Clock port is clk. Reset port is reset: synchronous, active-high.

## Operation
- Accept when in_valid && in_ready. Emit when out_valid && out_ready.
- The captured entry is the input bundle, except when in_miss_align=1:
  - ctrl_op=CTRL_OP_NOP, dst_addr=0, gpr_we_=1 (disabled), exp_code=ISA_EXP_MISS_ALIGN, out=0.
  - pc, en and br_flag pass through.
- States: EMPTY, ONE (main reg full) and TWO (main + skid full; skid build only).
  - EMPTY→ONE on accept.
  - ONE→ONE on accept+emit.
  - ONE→EMPTY on emit without accept.
  - ONE→TWO on accept without emit.
  - TWO→ONE on emit: skid moves to main, in_ready=0 so there is no accept in TWO.
- Order is strict FIFO. No entry is dropped or duplicated.
- flush=1: next state EMPTY. All held entries and any same-cycle input are discarded. Flush has priority over accept and emit. in_ready during the flush cycle follows normal rules, but nothing is stored.
- Reset and flush load the reset value into every payload register:
  - pc=0, en=0, br_flag=0, ctrl_op=CTRL_OP_NOP, dst_addr=0, gpr_we_=1, exp_code=ISA_EXP_NO_EXP, out=0.
  - Reset sets out_valid=0. Reset mid-operation behaves identically to flush.
- Payload outputs are held stable while out_valid && !out_ready.
- Bubbles (in_valid=0) never alter the held outputs.

## Timing
- Latency: an entry accepted at edge N is visible on the outputs with out_valid=1 after edge N.
- Throughput: 1 entry/cycle when out_ready stays high.
- Skid build: in_ready = (state != TWO). It is driven purely from registers, with no combinational out_ready→in_ready path.
- After reset: out_valid=0 and in_ready=1 in the first cycle.
- A skid→main transfer and out_valid update take effect at the same edge as the emit.

## Configuration
- MEM_STAGE_SKID_EN defined:
  - Two-entry skid buffer with the TWO state.
  - in_ready is registered.
  - The upstream stage can register its valid without seeing same-cycle backpressure.
- Undefined:
  - Single entry, states EMPTY/ONE only.
  - in_ready = !out_valid || out_ready (combinational).
  - Skid registers are not instantiated. All other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - CTRL_OP_NOP, ISA_EXP_NO_EXP and ISA_EXP_MISS_ALIGN.
  - The state encoding (EMPTY/ONE/TWO).
  - A packed entry type: pc, en, br_flag, ctrl_op, dst_addr, gpr_we_, exp_code, out.
- One sub-module is natural: mem_entry_fmt, the combinational exception-override formatter. It is instantiated once at the input so that main and skid store identical formatted entries.

## Test plan
- Stream: in_pc=0x100,0x104,0x108 on consecutive cycles with out_ready=1 → outputs show the same pcs one cycle later, out_valid continuous, in_ready never low.
- Misalign: in_pc=0x200, in_dst_addr=7, in_gpr_we_=0, in_out=0xDEADBEEF, in_miss_align=1 → out_pc=0x200, out_dst_addr=0, out_gpr_we_=1, out_exp_code=ISA_EXP_MISS_ALIGN, out_out=0.
- Backpressure (skid build): out_ready=0, send 0x300 and 0x304 → in_ready=0 after the second accept. Raise out_ready → 0x300 then 0x304 are emitted in order and in_ready returns to 1.
- Flush with a full buffer plus in_valid=1 (0x400) → next cycle out_valid=0, every payload at its reset value, 0x400 never emitted.
- Reset mid-stream while out_valid=1 → after the edge out_valid=0, out_ctrl_op=CTRL_OP_NOP, out_gpr_we_=1. The next accepted entry, 0x500, appears normally.
- Non-skid build: out_ready=0 with out_valid=1 → in_ready=0 in the same cycle. Raise out_ready → in_ready=1 in the same cycle.
